// File: rtl/dm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dm_arbiter                                                      |
// | Purpose  : Round-robin two-master arbiter for the shared Data_Memory port, |
// |            with a watchdog that aborts unacknowledged accesses.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dm_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          i_sys_clk,
    input  logic          i_reset,
    input  logic          i_m0_cs,
    input  logic          i_m0_rd,
    input  logic          i_m0_wr,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_din,
    output logic [DW-1:0] o_m0_dout,
    output logic          o_m0_mrdy,
    output logic          o_m0_err,
    input  logic          i_m1_cs,
    input  logic          i_m1_rd,
    input  logic          i_m1_wr,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_din,
    output logic [DW-1:0] o_m1_dout,
    output logic          o_m1_mrdy,
    output logic          o_m1_err,
    output logic          o_dm_cs,
    output logic          o_dm_rd,
    output logic          o_dm_wr,
    output logic [AW-1:0] o_dm_addr,
    output logic [DW-1:0] o_dm_din,
    input  logic [DW-1:0] i_dm_dout,
    input  logic          i_dm_mrdy,
    output logic [1:0]    o_grant,
    output logic          o_busy
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ACCESS  = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [1:0]    r_state;
    logic          r_last;      // 1 = m1 was served last
    logic [7:0]    r_cnt;

    logic          w_m0_req;
    logic          w_m1_req;
    logic          w_pick_m1;
    logic          w_timeout;
    logic          w_finish;
    logic [DW-1:0] w_rdata;

    // cs with rd == wr is not a request at all
    assign w_m0_req  = i_m0_cs & (i_m0_rd ^ i_m0_wr);
    assign w_m1_req  = i_m1_cs & (i_m1_rd ^ i_m1_wr);
    assign w_pick_m1 = w_m1_req & (~w_m0_req | ~r_last);
    assign w_timeout = (r_cnt + 8'd1) == c_TIMEOUT;
    assign w_finish  = i_dm_mrdy | w_timeout;
    assign w_rdata   = (i_dm_mrdy & o_dm_rd) ? i_dm_dout : '0;

    always_ff @(posedge i_sys_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= c_IDLE;
            r_last    <= 1'b1;
            r_cnt     <= 8'd0;
            o_dm_cs   <= 1'b0;
            o_dm_rd   <= 1'b0;
            o_dm_wr   <= 1'b0;
            o_dm_addr <= '0;
            o_dm_din  <= '0;
            o_grant   <= 2'b00;
            o_busy    <= 1'b0;
            o_m0_mrdy <= 1'b0;
            o_m0_err  <= 1'b0;
            o_m0_dout <= '0;
            o_m1_mrdy <= 1'b0;
            o_m1_err  <= 1'b0;
            o_m1_dout <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_m0_req || w_m1_req) begin
                        r_state <= c_ACCESS;
                        r_cnt   <= 8'd0;
                        o_dm_cs <= 1'b1;
                        o_busy  <= 1'b1;
                        if (w_pick_m1) begin
                            o_grant   <= 2'b10;
                            o_dm_rd   <= i_m1_rd;
                            o_dm_wr   <= i_m1_wr;
                            o_dm_addr <= i_m1_addr;
                            o_dm_din  <= i_m1_din;
                        end else begin
                            o_grant   <= 2'b01;
                            o_dm_rd   <= i_m0_rd;
                            o_dm_wr   <= i_m0_wr;
                            o_dm_addr <= i_m0_addr;
                            o_dm_din  <= i_m0_din;
                        end
                    end
                end
                c_ACCESS: begin
                    if (w_finish) begin
                        r_state   <= c_DONE;
                        r_last    <= o_grant[1];
                        o_dm_cs   <= 1'b0;
                        o_dm_rd   <= 1'b0;
                        o_dm_wr   <= 1'b0;
                        o_m0_mrdy <= o_grant[0];
                        o_m0_err  <= o_grant[0] & ~i_dm_mrdy;
                        o_m0_dout <= o_grant[0] ? w_rdata : '0;
                        o_m1_mrdy <= o_grant[1];
                        o_m1_err  <= o_grant[1] & ~i_dm_mrdy;
                        o_m1_dout <= o_grant[1] ? w_rdata : '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_DONE: begin
                    r_state   <= c_IDLE;
                    o_grant   <= 2'b00;
                    o_busy    <= 1'b0;
                    o_m0_mrdy <= 1'b0;
                    o_m0_err  <= 1'b0;
                    o_m0_dout <= '0;
                    o_m1_mrdy <= 1'b0;
                    o_m1_err  <= 1'b0;
                    o_m1_dout <= '0;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dm_arbiter                                                   |
// | Purpose  : Self-checking bench for dm_arbiter: directed table, reset       |
// |            corner cases and randomized traffic against a reference model.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dm_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m_cs [2];
    logic        m_rd [2];
    logic        m_wr [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_din [2];
    logic [31:0] o_dout [2];
    logic        o_mrdy [2];
    logic        o_err [2];

    logic        dm_cs, dm_rd, dm_wr, dm_mrdy, busy;
    logic [31:0] dm_addr, dm_din, dm_dout;
    logic [1:0]  grant;

    logic [31:0] mem [256];      // the memory itself (environment)
    logic [31:0] ref_mem [256];  // model's view of what masters wrote
    int          last_m;         // model: port served last
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        int          k0;
        logic [31:0] a0;
        logic [31:0] d0;
        int          k1;
        logic [31:0] a1;
        logic [31:0] d1;
        int          lat;
        int          win;
        logic [31:0] rdat;
    } vec_t;

    vec_t tbl [14];

    dm_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) u_dut (
        .i_sys_clk (clk),
        .i_reset   (rst_n),
        .i_m0_cs   (m_cs[0]),
        .i_m0_rd   (m_rd[0]),
        .i_m0_wr   (m_wr[0]),
        .i_m0_addr (m_addr[0]),
        .i_m0_din  (m_din[0]),
        .o_m0_dout (o_dout[0]),
        .o_m0_mrdy (o_mrdy[0]),
        .o_m0_err  (o_err[0]),
        .i_m1_cs   (m_cs[1]),
        .i_m1_rd   (m_rd[1]),
        .i_m1_wr   (m_wr[1]),
        .i_m1_addr (m_addr[1]),
        .i_m1_din  (m_din[1]),
        .o_m1_dout (o_dout[1]),
        .o_m1_mrdy (o_mrdy[1]),
        .o_m1_err  (o_err[1]),
        .o_dm_cs   (dm_cs),
        .o_dm_rd   (dm_rd),
        .o_dm_wr   (dm_wr),
        .o_dm_addr (dm_addr),
        .o_dm_din  (dm_din),
        .i_dm_dout (dm_dout),
        .i_dm_mrdy (dm_mrdy),
        .o_grant   (grant),
        .o_busy    (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // kind: 0 keep, 1 none, 2 read, 3 write, 4 illegal (rd == wr)
    task automatic set_req(input int p, input int kind, input logic [31:0] a, input logic [31:0] d);
        logic b;
        if (kind == 0) return;
        b         = 1'($urandom_range(0, 1));
        m_cs[p]   = (kind != 1);
        m_rd[p]   = (kind == 2) || (kind == 4 && b);
        m_wr[p]   = (kind == 3) || (kind == 4 && b);
        m_addr[p] = a;
        m_din[p]  = d;
    endtask

    // Called at a negedge with the DUT idle and requests already presented.
    // lat = cycle on which memory answers (lat > TO means it never answers).
    task automatic txn(input int lat, input int win, input logic [31:0] rdat);
        int          w;
        int          ncs;
        logic        e;
        logic [31:0] exp_d;
        @(negedge clk);
        if (win == 0) begin
            chk("nogrant_grant", grant, 0);
            chk("nogrant_cs", dm_cs, 0);
            chk("nogrant_busy", busy, 0);
            return;
        end
        w   = win - 1;
        e   = (lat > TO);
        ncs = e ? TO : lat;
        chk("acc_grant", grant, (w == 0) ? 2'b01 : 2'b10);
        chk("acc_busy", busy, 1);
        chk("acc_cs", dm_cs, 1);
        chk("acc_rd", dm_rd, m_rd[w]);
        chk("acc_wr", dm_wr, m_wr[w]);
        chk("acc_addr", dm_addr, m_addr[w]);
        chk("acc_din", dm_din, m_din[w]);
        chk("acc_mrdy", {o_mrdy[0], o_mrdy[1]}, 0);
        for (int n = 1; n < ncs; n++) begin
            dm_dout = $urandom;
            @(negedge clk);
            chk("cs_hold", dm_cs, 1);
        end
        if (!e) begin
            dm_mrdy = 1'b1;
            dm_dout = dm_rd ? mem[dm_addr[7:0]] : $urandom;
            if (dm_wr) mem[dm_addr[7:0]] = dm_din;
        end
        @(negedge clk);
        dm_mrdy = 1'b0;
        exp_d   = (e || m_wr[w]) ? 32'h0 : rdat;
        chk("done_cs", dm_cs, 0);
        chk("done_busy", busy, 1);
        chk("done_grant", grant, (w == 0) ? 2'b01 : 2'b10);
        chk("done_mrdy", o_mrdy[w], 1);
        chk("done_err", o_err[w], e);
        chk("done_dout", o_dout[w], exp_d);
        chk("other_quiet", {o_mrdy[1-w], o_err[1-w], o_dout[1-w]}, 0);
        last_m = w;
        if (!e && m_wr[w]) ref_mem[m_addr[w][7:0]] = m_din[w];
        m_cs[w] = 1'b0;
        @(negedge clk);
        chk("idle_grant", grant, 0);
        chk("idle_busy", busy, 0);
        chk("idle_mrdy", {o_mrdy[0], o_mrdy[1]}, 0);
        chk("idle_cs", dm_cs, 0);
        chk("idle_addr_hold", dm_addr, m_addr[w]);
    endtask

    initial begin
        int          win, lat, r;
        logic        v0, v1;
        logic [31:0] rd;

        tbl[0]  = '{2, 32'h10, 32'h0,        1, 32'h0,  32'h0,        1,    1, 32'h12345678};
        tbl[1]  = '{1, 32'h0,  32'h0,        3, 32'h20, 32'hCAFEF00D, 2,    2, 32'h0};
        tbl[2]  = '{2, 32'h20, 32'h0,        1, 32'h0,  32'h0,        1,    1, 32'hCAFEF00D};
        tbl[3]  = '{1, 32'h0,  32'h0,        2, 32'h20, 32'h0,        1,    2, 32'hCAFEF00D};
        tbl[4]  = '{3, 32'h30, 32'h11111111, 3, 32'h34, 32'h22222222, 1,    1, 32'h0};
        tbl[5]  = '{2, 32'h30, 32'h0,        0, 32'h0,  32'h0,        3,    2, 32'h0};
        tbl[6]  = '{0, 32'h0,  32'h0,        2, 32'h34, 32'h0,        1,    1, 32'h11111111};
        tbl[7]  = '{2, 32'h40, 32'h0,        0, 32'h0,  32'h0,        2,    2, 32'h22222222};
        tbl[8]  = '{0, 32'h0,  32'h0,        4, 32'h50, 32'h0,        TO+1, 1, 32'h0};
        tbl[9]  = '{2, 32'h10, 32'h0,        0, 32'h0,  32'h0,        1,    1, 32'h12345678};
        tbl[10] = '{4, 32'h60, 32'h0,        2, 32'h10, 32'h0,        2,    2, 32'h12345678};
        tbl[11] = '{0, 32'h0,  32'h0,        1, 32'h0,  32'h0,        0,    0, 32'h0};
        tbl[12] = '{1, 32'h0,  32'h0,        1, 32'h0,  32'h0,        0,    0, 32'h0};
        tbl[13] = '{2, 32'h20, 32'h0,        1, 32'h0,  32'h0,        TO,   1, 32'hCAFEF00D};

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h10] = 32'h12345678;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int p = 0; p < 2; p++) set_req(p, 1, 32'h0, 32'h0);
        dm_mrdy = 1'b0;
        dm_dout = 32'h0;
        last_m  = 1;

        #2;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {dm_cs, dm_rd, dm_wr}, 0);
        chk("rst_addr", dm_addr, 0);
        chk("rst_din", dm_din, 0);
        chk("rst_resp", {o_mrdy[0], o_err[0], o_dout[0], o_mrdy[1], o_err[1], o_dout[1]}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            set_req(0, tbl[i].k0, tbl[i].a0, tbl[i].d0);
            set_req(1, tbl[i].k1, tbl[i].a1, tbl[i].d1);
            txn(tbl[i].lat, tbl[i].win, tbl[i].rdat);
        end

        // Reset in the middle of an access: everything drops without a clock
        set_req(0, 2, 32'h10, 32'h0);
        set_req(1, 1, 32'h0, 32'h0);
        @(negedge clk);
        chk("mid_cs_before", dm_cs, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", dm_cs, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", dm_addr, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_rst_nomrdy", {o_mrdy[0], o_mrdy[1]}, 0);
        end
        set_req(0, 2, 32'h20, 32'h0);
        set_req(1, 2, 32'h10, 32'h0);
        rst_n  = 1'b1;
        last_m = 1;
        txn(1, 1, ref_mem[8'h20]);

        for (int it = 0; it < 300; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(m_cs[p] && (m_rd[p] ^ m_wr[p]))) begin
                    r = $urandom_range(0, 9);
                    set_req(p, (r < 2) ? 1 : (r < 6) ? 2 : (r < 9) ? 3 : 4,
                            $urandom, $urandom);
                end
            end
            v0 = m_cs[0] && (m_rd[0] ^ m_wr[0]);
            v1 = m_cs[1] && (m_rd[1] ^ m_wr[1]);
            if (v0 && v1) win = (last_m == 0) ? 2 : 1;
            else if (v0)  win = 1;
            else if (v1)  win = 2;
            else          win = 0;
            r = $urandom_range(0, 9);
            if (r < 6)      lat = $urandom_range(1, 3);
            else if (r < 8) lat = $urandom_range(4, TO);
            else            lat = TO + 1;
            rd = (win != 0) ? ref_mem[m_addr[win-1][7:0]] : 32'h0;
            txn(lat, win, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
